// File: rtl/seq_multiplier_8bit_pkg.sv
// Purpose: shared state encodings and width constants for the sequential multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_multiplier_8bit_pkg;

  localparam int OP_W   = 8;               // operand width
  localparam int PROD_W = 16;              // product width
  localparam int ITER_N = 8;               // shift-add iterations per multiply
  localparam int CNT_W  = $clog2(ITER_N);  // iteration counter width

  // Last counter value; the step taken at this count is the final one.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_multiplier_8bit_if.sv
// Purpose: request/result bundle between a multiply requester and the multiplier.
// Latency: n/a (wires only).
// Backpressure: none; requests are only taken while the multiplier is idle.
interface seq_multiplier_8bit_if;
  import seq_multiplier_8bit_pkg::*;

  logic              start;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              busy;
  logic              done;
  logic [PROD_W-1:0] p;

  // Requester side: drives operands, observes status and product.
  modport master (
    output start, a, b,
    input  busy, done, p
  );

  // Multiplier side.
  modport slave (
    input  start, a, b,
    output busy, done, p
  );

endinterface

// File: rtl/seq_multiplier_8bit_cla.sv
// Purpose: 8-bit carry-lookahead adder, every carry built from generate/propagate terms.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module Carry_Look_Ahead_Adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c0,
  output logic [7:0] s,
  output logic       c8
);

  logic [7:0] gen;
  logic [7:0] prop;
  logic [8:0] carry;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Each carry is the OR of every generate term that can propagate up to it,
  // so no carry depends on a lower carry signal (flat lookahead, no ripple).
  always_comb begin : lookahead
    logic acc;
    logic run;
    carry    = '0;
    acc      = 1'b0;
    run      = 1'b0;
    carry[0] = c0;
    for (int i = 0; i < 8; i++) begin
      acc = gen[i];
      run = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (run & gen[j]);
        run = run & prop[j];
      end
      acc = acc | (run & c0);
      carry[i+1] = acc;
    end
  end

  assign s  = prop ^ carry[7:0];
  assign c8 = carry[8];

endmodule

// File: rtl/seq_multiplier_8bit.sv
// Purpose: unsigned 8x8 shift-and-add multiplier, one partial-product step per cycle.
// Latency: accept in IDLE, 8 CALC cycles, then a 1-cycle done pulse; 10 cycles per op.
// Backpressure: start is ignored while busy or done; no request queuing.
module seq_multiplier_8bit
  import seq_multiplier_8bit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  seq_multiplier_8bit_if.slave  bus
);

  state_t             state_q;
  state_t             state_d;
  logic [OP_W-1:0]    mcand_q;
  logic [OP_W-1:0]    mplier_q;
  logic [OP_W-1:0]    upper_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PROD_W-1:0]  p_q;

  logic [OP_W-1:0]    addend;
  logic [OP_W-1:0]    sum;
  logic               c8;
  logic [OP_W-1:0]    upper_nxt;
  logic [OP_W-1:0]    mplier_nxt;
  logic               last_step;

  // Partial product is added only when the current multiplier LSB is set.
  assign addend = mplier_q[0] ? mcand_q : '0;

  Carry_Look_Ahead_Adder_8bit u_cla (
    .a  (upper_q),
    .b  (addend),
    .c0 (1'b0),
    .s  (sum),
    .c8 (c8)
  );

  // {c8, sum, multiplier} shifted right by one: the carry drops into the top
  // of the accumulator and the sum LSB moves into the multiplier register.
  assign upper_nxt  = {c8, sum[OP_W-1:1]};
  assign mplier_nxt = {sum[0], mplier_q[OP_W-1:1]};
  assign last_step  = (cnt_q == LAST_ITER);

  // State register; reset wins over any request at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one shift-add per CALC cycle, and
  // product capture on the final step; p is otherwise held.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      upper_q  <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mcand_q  <= bus.a;
            mplier_q <= bus.b;
            upper_q  <= '0;
            cnt_q    <= '0;
          end
        end
        CALC: begin
          upper_q  <= upper_nxt;
          mplier_q <= mplier_nxt;
          cnt_q    <= cnt_q + 1'b1;
          if (last_step) begin
            p_q <= {upper_nxt, mplier_nxt};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q == CALC);
  assign bus.done = (state_q == DONE);
  assign bus.p    = p_q;

endmodule

// File: tb/tb_seq_multiplier_8bit.sv
// Purpose: self-checking bench for seq_multiplier_8bit (directed table, corner sequences, random back-to-back).
// Latency: expects 8 busy cycles after the accepting edge, then a 1-cycle done; ops every 10 cycles with start held.
// Backpressure: start pulses during an operation must be ignored.
module tb_seq_multiplier_8bit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  seq_multiplier_8bit_if mif();

  seq_multiplier_8bit dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[8];

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endfunction

  // One isolated multiply: checks product, 8 busy cycles, done 8 edges after
  // accept, p held throughout CALC, and done lasting exactly one cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_p, input string nm);
    logic [15:0] p_before;
    int busy_cnt;
    int lat;
    bit p_moved;
    p_before = mif.p;
    mif.start = 1'b1;
    mif.a = a;
    mif.b = b;
    tick();
    mif.start = 1'b0;
    busy_cnt = 0;
    lat = 0;
    p_moved = 0;
    while (!mif.done && lat < 20) begin
      if (mif.busy) busy_cnt++;
      if (mif.p !== p_before) p_moved = 1;
      mif.a = 8'($urandom);
      mif.b = 8'($urandom);
      tick();
      lat++;
    end
    chk({nm, "_done_seen"}, 32'(mif.done), 32'd1);
    chk({nm, "_latency"}, 32'(lat), 32'd8);
    chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
    chk({nm, "_p_held_in_calc"}, 32'(p_moved), 32'd0);
    chk({nm, "_p"}, 32'(mif.p), 32'(exp_p));
    tick();
    chk({nm, "_done_one_cycle"}, 32'(mif.done), 32'd0);
    chk({nm, "_p_held_after"}, 32'(mif.p), 32'(exp_p));
  endtask

  initial begin : main
    logic [15:0] exp_q[$];
    logic [15:0] e;
    int done_cnt;
    int last_done;
    int spacing_bad;
    int ops_checked;

    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    mif.start = 1'b0;
    mif.a = '0;
    mif.b = '0;

    vecs[0] = '{8'h0D, 8'h0B, 16'h008F};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h00, 8'hA5, 16'h0000};
    vecs[3] = '{8'h80, 8'h02, 16'h0100};
    vecs[4] = '{8'h03, 8'h05, 16'h000F};
    vecs[5] = '{8'hFF, 8'h00, 16'h0000};
    vecs[6] = '{8'h01, 8'hFF, 16'h00FF};
    vecs[7] = '{8'hAA, 8'h55, 16'h3872};

    tick();
    tick();
    chk("reset_busy", 32'(mif.busy), 32'd0);
    chk("reset_done", 32'(mif.done), 32'd0);
    chk("reset_p", 32'(mif.p), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_no_start_busy", 32'(mif.busy), 32'd0);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
    end

    // start re-pulsed during CALC with new operands must be ignored.
    mif.start = 1'b1;
    mif.a = 8'h12;
    mif.b = 8'h34;
    tick();
    mif.start = 1'b0;
    tick();
    tick();
    mif.start = 1'b1;
    mif.a = 8'hFF;
    mif.b = 8'hFF;
    tick();
    mif.start = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (mif.done) begin
        done_cnt++;
        chk("ignore_start_p", 32'(mif.p), 32'h03A8);
      end
      tick();
    end
    chk("ignore_start_done_pulses", 32'(done_cnt), 32'd1);

    // Reset on the 4th CALC cycle aborts the operation.
    mif.start = 1'b1;
    mif.a = 8'hC8;
    mif.b = 8'h07;
    tick();
    mif.start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_busy_before_rst", 32'(mif.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(mif.busy), 32'd0);
    chk("abort_done", 32'(mif.done), 32'd0);
    chk("abort_p", 32'(mif.p), 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (mif.done) done_cnt++;
      tick();
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    run_op(8'h03, 8'h05, 16'h000F, "after_abort");

    // Reset wins over start at the same edge.
    rst = 1'b1;
    mif.start = 1'b1;
    tick();
    chk("rst_priority_busy", 32'(mif.busy), 32'd0);
    rst = 1'b0;
    mif.start = 1'b0;
    tick();

    // Random back-to-back with start held high: an idle multiplier takes a
    // request on the first edge and then every 10 edges; operands change
    // every cycle so only those present at an accepting edge may count.
    spacing_bad = 0;
    ops_checked = 0;
    last_done = -1;
    mif.start = 1'b1;
    mif.a = 8'hFF;
    mif.b = 8'hFF;
    for (int c = 0; c < 2000; c++) begin
      if (c % 10 == 0) exp_q.push_back(16'(mif.a) * 16'(mif.b));
      tick();
      if (mif.done) begin
        if (exp_q.size() == 0) begin
          chk("b2b_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          n_cmp++;
          ops_checked++;
          if (mif.p !== e) begin
            n_err++;
            $display("FAIL b2b_p at cycle %0d: got 0x%0h, want 0x%0h", c, mif.p, e);
          end
        end
        if (last_done >= 0 && (c - last_done) != 10) spacing_bad++;
        last_done = c;
      end
      mif.a = 8'($urandom);
      mif.b = 8'($urandom);
      if ($urandom_range(0, 15) == 0) mif.a = 8'h00;
      if ($urandom_range(0, 15) == 0) mif.b = 8'hFF;
    end
    mif.start = 1'b0;
    chk("b2b_ops_checked", 32'(ops_checked), 32'd200);
    chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("b2b_done_spacing", 32'(spacing_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
